imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time program loader that sits directly upstream of the instruction memory. It accepts a byte stream from a host link (valid/ready), assembles little-endian 32-bit words and writes them sequentially into the instruction memory through its we_re/request/mask/address/data_in/valid port. It holds the core in reset until the programmed word count has been written, then releases it.

Parameters:
ADDR_W, 8, word-address width driven to the instruction memory (matches pc_address[9:2]).
MAX_WORDS, 256, maximum loadable words; must equal 2**ADDR_W.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE
word_count  input  ADDR_W+1  number of words to load (1..MAX_WORDS), sampled on accepted start
s_data  input  8  host byte
s_valid  input  1  host byte valid
s_ready  output  1  loader accepts byte this cycle
mem_we_re  output  1  1 = write to instruction memory
mem_request  output  1  memory access request
mem_mask  output  4  byte-enable mask
mem_address  output  ADDR_W  word address
mem_data_in  output  32  write data
mem_valid  input  1  memory write-accepted acknowledge
core_rst  output  1  reset to core; high while not loaded
busy  output  1  load in progress
done  output  1  load completed successfully
error  output  1  last start rejected or load failed

Behaviour:
- Reset (async, rst=1): state IDLE; s_ready=0, mem_we_re=0, mem_request=0, mem_mask=0, mem_address=0, mem_data_in=0, busy=0, done=0, error=0, core_rst=1. Reset mid-load aborts; memory content is not cleared.
- States: IDLE, COLLECT, WRITE, WAIT_ACK, DONE (plus CHECK with option).
- IDLE/DONE: on start with word_count in 1..MAX_WORDS: latch count, clear word index and byte counter, error=0, done=0, core_rst=1, busy=1, go COLLECT. word_count=0 or >MAX_WORDS: error=1, stay in state (DONE keeps core_rst=0 and done=1). start in any other state is ignored.
- COLLECT: s_ready=1. Byte accepted when s_valid&s_ready. Byte n (0..3) goes to bits [8n+7:8n] of the word register. After byte 3, go WRITE next cycle; s_ready=0 outside COLLECT.
- WRITE: exactly one cycle with mem_request=1, mem_we_re=1, mem_mask=4'hF, mem_address=word index, mem_data_in=assembled word; go WAIT_ACK.
- WAIT_ACK: request deasserted, address/data held. Wait for mem_valid (first cycle after WRITE onward; a mem_valid during WRITE is ignored). On mem_valid: if index==count-1 go DONE (or CHECK), else index+1, go COLLECT.
- DONE: busy=0, done=1, core_rst=0 (registered, deasserts the cycle DONE is entered). Remains until start or rst.
- Latency per word with back-to-back bytes and immediate ack: 4 accept cycles + 1 WRITE + 1 ACK cycle = 6 cycles.
- Index is ADDR_W bits; count=MAX_WORDS writes addresses 0..MAX_WORDS-1 with no wrap.
- Byte counter 2 bits; stall (s_valid=0) holds all state indefinitely; no timeout.

Optional Feature:
LOADER_CHECKSUM_EN: defined -> after the last word ack, state CHECK with s_ready=1 accepts one trailer byte; it must equal the XOR of all payload bytes. Match -> DONE. Mismatch -> error=1, busy=0, core_rst stays 1, return IDLE. Not defined -> no trailer byte, last ack goes straight to DONE, error only set by bad word_count.

Test Plan:
- Reset -> core_rst=1, s_ready=0, mem_request=0, all other outputs 0.
- start, word_count=2, bytes 78 56 34 12 EF BE AD DE, immediate ack -> writes 0x12345678 @0, 0xDEADBEEF @1, mask F, done=1, core_rst=0.
- Same load with mem_valid delayed 3 cycles and s_valid gaps -> identical writes, mem_address/data held stable during WAIT_ACK, s_ready=0 while waiting.
- start with word_count=0 -> error=1, stays IDLE, no mem_request; start while busy -> ignored.
- word_count=256, incrementing bytes -> last write at address 0xFF, no wrap; rst mid-load at word 10 -> outputs return to reset values immediately.
- LOADER_CHECKSUM_EN, 1 word 01 02 04 08, trailer 0x0F -> done; trailer 0x00 -> error=1, core_rst=1, IDLE.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a host byte stream and writes them into
// instruction memory, holding the core in reset until loaded. Optional trailer check: LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we_re,
    output logic              mem_request,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    input  logic              mem_valid,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WRITE, S_WAIT_ACK, S_DONE, S_CHECK
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [31:0]         word_q, word_d;
    logic                s_ready_q, s_ready_d;
    logic                mem_req_q, mem_req_d;
    logic [3:0]          mem_mask_q, mem_mask_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_data_q, mem_data_d;
    logic                core_rst_q, core_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic start_ok;
    logic byte_acc;
    logic last_word;

    assign start_ok  = (word_count != '0) && (word_count <= CNT_W'(MAX_WORDS));
    assign byte_acc  = s_valid & s_ready_q;
    assign last_word = ({1'b0, idx_q} == (count_q - CNT_W'(1)));

    // Next-state and next-output logic; all outputs are registered from the _d values
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        word_d     = word_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        core_rst_d = core_rst_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (start_ok) begin
                        count_d    = word_count;
                        idx_d      = '0;
                        bcnt_d     = '0;
                        error_d    = 1'b0;
                        done_d     = 1'b0;
                        core_rst_d = 1'b1;
                        busy_d     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = '0;
`endif
                        state_d    = S_COLLECT;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (byte_acc) begin
                    word_d[{bcnt_q, 3'b000} +: 8] = s_data;
                    bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ s_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        mem_addr_d = idx_q;
                        mem_data_d = word_d;
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (mem_valid) begin
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d    = S_CHECK;
`else
                        state_d    = S_DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
`endif
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_COLLECT;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (byte_acc) begin
                    busy_d = 1'b0;
                    if (s_data == csum_q) begin
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        s_ready_d  = (state_d == S_COLLECT) || (state_d == S_CHECK);
        mem_req_d  = (state_d == S_WRITE);
        mem_mask_d = (state_d == S_WRITE) ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
            s_ready_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_mask_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            word_q     <= word_d;
            s_ready_q  <= s_ready_d;
            mem_req_q  <= mem_req_d;
            mem_mask_q <= mem_mask_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign s_ready     = s_ready_q;
    assign mem_we_re   = mem_req_q;
    assign mem_request = mem_req_q;
    assign mem_mask    = mem_mask_q;
    assign mem_address = mem_addr_q;
    assign mem_data_in = mem_data_q;
    assign core_rst    = core_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start validation table plus directed load sequences.
module tb_imem_loader;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MAX_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              mem_we_re;
    logic              mem_request;
    logic [3:0]        mem_mask;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic              mem_valid;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mem_we_re(mem_we_re), .mem_request(mem_request), .mem_mask(mem_mask),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_valid(mem_valid),
        .core_rst(core_rst), .busy(busy), .done(done), .error(error)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int c0     = 0;
    int ack_delay = 0;
    bit spurious  = 1'b0;

    logic [7:0]  bytes[$];
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_mask[$];

    typedef struct {
        logic [8:0] wc;
        logic       exp_error;
        logic       exp_busy;
        logic       exp_ready;
    } vec_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [50:0] outs();
        return {s_ready, mem_we_re, mem_request, mem_mask, mem_address,
                mem_data_in, core_rst, busy, done, error};
    endfunction

    // Memory responder: logs each write, optionally pulses mem_valid during WRITE, acks after ack_delay
    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        mem_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_request && !rst) begin
                a = mem_address;
                d = mem_data_in;
                wr_addr.push_back(a);
                wr_data.push_back(d);
                wr_mask.push_back(mem_mask);
                if (spurious) mem_valid = 1'b1;
                @(posedge clk);
                #1;
                mem_valid = 1'b0;
                for (int k = 0; k < ack_delay; k++) begin
                    chk("hold_addr", 64'(mem_address), 64'(a));
                    chk("hold_data", 64'(mem_data_in), 64'(d));
                    chk("ready_low_in_wait", 64'(s_ready), 64'd0);
                    chk("req_low_in_wait", 64'(mem_request), 64'd0);
                    @(posedge clk);
                    #1;
                end
                mem_valid = 1'b1;
                @(posedge clk);
                #1;
                mem_valid = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        #2;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_load(input int wc);
        wr_addr.delete();
        wr_data.delete();
        wr_mask.delete();
        start      = 1'b1;
        word_count = 9'(wc);
        tick();
        start = 1'b0;
        c0    = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_data  = b;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        if (!s_ready) chk("s_ready_timeout", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_all(input bit gaps);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], (gaps && (i % 3 == 1)) ? 2 : 0);
            x = x ^ bytes[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, 0);
`endif
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    vec_t vecs[6];
    int   bad;

    initial begin
        vecs[0] = '{9'd0,   1'b1, 1'b0, 1'b0};
        vecs[1] = '{9'd257, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{9'd511, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{9'd1,   1'b0, 1'b1, 1'b1};
        vecs[4] = '{9'd256, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{9'd100, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; word_count = '0; s_data = '0; s_valid = 1'b0;
        #12;
        chk("reset_outputs", 64'(outs()), 64'h8);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_outputs", 64'(outs()), 64'h8);

        // Start acceptance table
        foreach (vecs[i]) begin
            do_reset();
            start_load(int'(vecs[i].wc));
            chk($sformatf("start_err_wc%0d", vecs[i].wc), 64'(error), 64'(vecs[i].exp_error));
            chk($sformatf("start_busy_wc%0d", vecs[i].wc), 64'(busy), 64'(vecs[i].exp_busy));
            chk($sformatf("start_rdy_wc%0d", vecs[i].wc), 64'(s_ready), 64'(vecs[i].exp_ready));
            tick();
            chk($sformatf("no_req_wc%0d", vecs[i].wc), 64'(mem_request), 64'd0);
        end

        // Two words, back-to-back bytes, immediate ack
        do_reset();
        bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ack_delay = 0; spurious = 1'b0;
        start_load(2);
        send_all(1'b0);
        wait_done("two_word_done");
`ifdef LOADER_CHECKSUM_EN
        chk("two_word_latency", 64'(cyc - c0), 64'd13);
`else
        chk("two_word_latency", 64'(cyc - c0), 64'd12);
`endif
        chk("two_word_nwr", 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            chk("w0_addr", 64'(wr_addr[0]), 64'h0);
            chk("w0_data", 64'(wr_data[0]), 64'h12345678);
            chk("w0_mask", 64'(wr_mask[0]), 64'hF);
            chk("w1_addr", 64'(wr_addr[1]), 64'h1);
            chk("w1_data", 64'(wr_data[1]), 64'hDEADBEEF);
            chk("w1_mask", 64'(wr_mask[1]), 64'hF);
        end
        chk("two_word_final", 64'({core_rst, busy, done, error, s_ready}), 64'b00100);

        // Bad start while DONE keeps the loaded state
        start_load(0);
        chk("done_badstart", 64'({core_rst, busy, done, error}), 64'b0011);

        // Same load, delayed ack, byte gaps, spurious mem_valid during WRITE
        do_reset();
        ack_delay = 3; spurious = 1'b1;
        start_load(2);
        send_all(1'b1);
        wait_done("delayed_done");
        chk("delayed_nwr", 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            chk("d0", 64'({wr_addr[0], wr_data[0], wr_mask[0]}), 64'({8'h00, 32'h12345678, 4'hF}));
            chk("d1", 64'({wr_addr[1], wr_data[1], wr_mask[1]}), 64'({8'h01, 32'hDEADBEEF, 4'hF}));
        end
        ack_delay = 0; spurious = 1'b0;

        // Start while busy is ignored, including the new count
        do_reset();
        start_load(1);
        send_byte(8'hAA, 0);
        start = 1'b1; word_count = 9'd0;
        tick();
        start = 1'b0;
        chk("busy_start_err", 64'(error), 64'd0);
        chk("busy_start_busy", 64'(busy), 64'd1);
        start = 1'b1; word_count = 9'd5;
        tick();
        start = 1'b0;
        bytes = '{8'hBB, 8'hCC, 8'hDD};
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 0);
`endif
        wait_done("one_word_done");
        chk("one_word_nwr", 64'(wr_data.size()), 64'd1);
        if (wr_data.size() == 1) chk("one_word_data", 64'(wr_data[0]), 64'hDDCCBBAA);

        // Full 256-word load restarted from DONE
        bytes.delete();
        for (int i = 0; i < 1024; i++) bytes.push_back(8'(i));
        start_load(256);
        chk("restart_state", 64'({core_rst, busy, done, error}), 64'b1100);
        send_all(1'b0);
        wait_done("full_done");
        chk("full_nwr", 64'(wr_addr.size()), 64'd256);
        bad = 0;
        for (int k = 0; k < wr_addr.size(); k++) begin
            if (wr_addr[k] !== 8'(k)) bad++;
            if (wr_data[k] !== {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}) bad++;
        end
        chk("full_bad_entries", 64'(bad), 64'd0);
        if (wr_addr.size() == 256) begin
            chk("full_last_addr", 64'(wr_addr[255]), 64'hFF);
            chk("full_last_data", 64'(wr_data[255]), 64'hFFFEFDFC);
        end
        chk("full_core_rst", 64'(core_rst), 64'd0);

        // Asynchronous reset in the middle of word 10
        do_reset();
        start_load(20);
        bytes.delete();
        for (int i = 0; i < 42; i++) bytes.push_back(8'(i + 7));
        for (int i = 0; i < 42; i++) send_byte(bytes[i], 0);
        chk("midload_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midload_reset_outputs", 64'(outs()), 64'h8);
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_outputs", 64'(outs()), 64'h8);

`ifdef LOADER_CHECKSUM_EN
        // Trailer checksum: match then mismatch
        do_reset();
        start_load(1);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
        send_byte(8'h0F, 0);
        chk("csum_ok", 64'({core_rst, busy, done, error}), 64'b0010);
        do_reset();
        start_load(1);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        chk("csum_bad", 64'({core_rst, busy, done, error, s_ready}), 64'b10010);
        tick();
        chk("csum_bad_idle", 64'({s_ready, mem_request}), 64'b00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
